// File: rtl/alu_div_pkg.sv
// Shared definitions for the iterative divider: FSM state type and iteration sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int DIV_ITER  = 32;  // restoring steps per division
   localparam int DIV_CNT_W = 6;   // iteration counter width

endpackage

// File: rtl/alu_div.sv
// Iterative restoring radix-2 DIV/DIVU unit for the E stage; quotient on lo_o, remainder on hi_o.
// Latency: 33 stall cycles (start cycle + 32 steps), then one DONE cycle; 1 stall cycle for a zero
//          divisor when DIV_ZERO_FAST_EN is defined.
// Backpressure: alu_stall_o holds F..M while dividing; DONE is held while stall_i=1; flush_i aborts.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start_i, signed_i      DIV/DIVU in E (held while E is stalled), 1 = signed
//   a_i, b_i               dividend, divisor
//   flush_i, stall_i       E-stage flush, external E stall (freezes DONE)
//   alu_stall_o, done_o    stall request, results valid
//   hi_o, lo_o             remainder, quotient (held until the next DONE)
// Configuration macro: DIV_ZERO_FAST_EN (zero divisor skips the 32 iterations).
module alu_div
   import alu_div_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic        signed_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        alu_stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   div_state_t           state_q, state_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          quo_q, quo_d;   // dividend shifts out, quotient bits shift in
   logic [31:0]          rem_q, rem_d;   // partial remainder
   logic [31:0]          dvs_q, dvs_d;   // |divisor|
   logic                 q_neg_q, q_neg_d;
   logic                 r_neg_q, r_neg_d;
   logic                 zero_q, zero_d;
   logic [31:0]          hi_q, hi_d;
   logic [31:0]          lo_q, lo_d;

   logic [32:0]          shifted;
   logic [32:0]          diff;
   logic                 step_ge;
   logic [31:0]          step_rem;
   logic [31:0]          step_quo;

   function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return apply_sign(v, sgn & v[31]);
   endfunction

   // One restoring step: shift the next dividend bit in, subtract if it fits.
   assign shifted  = {rem_q, quo_q[31]};
   assign diff     = shifted - {1'b0, dvs_q};
   assign step_ge  = ~diff[32];
   assign step_rem = step_ge ? diff[31:0] : shifted[31:0];
   assign step_quo = {quo_q[30:0], step_ge};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               state_d = CALC;
               cnt_d   = '0;
               quo_d   = magnitude(a_i, signed_i);
               dvs_d   = magnitude(b_i, signed_i);
               rem_d   = '0;
               q_neg_d = signed_i & (a_i[31] ^ b_i[31]);
               r_neg_d = signed_i & a_i[31];
               zero_d  = (b_i == 32'd0);
`ifdef DIV_ZERO_FAST_EN
               if (b_i == 32'd0) begin
                  state_d = DONE;
                  lo_d    = '1;
                  hi_d    = a_i;
               end
`endif
            end
         end
         CALC: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               quo_d = step_quo;
               rem_d = step_rem;
               cnt_d = cnt_q + DIV_CNT_W'(1);
               if (cnt_q == DIV_CNT_W'(DIV_ITER - 1)) begin
                  state_d = DONE;
                  // With a zero divisor every step subtracts nothing, so the remainder
                  // ends as |a|; the remainder sign restores the raw dividend. Only the
                  // quotient needs overriding.
                  lo_d    = zero_q ? 32'hFFFF_FFFF : apply_sign(step_quo, q_neg_q);
                  hi_d    = apply_sign(step_rem, r_neg_q);
               end
            end
         end
         DONE: begin
            if (flush_i || !stall_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // resetn gates the combinational stall so a start_i held through reset cannot stall the pipe.
   assign alu_stall_o = resetn & ~flush_i &
                        (((state_q == IDLE) & start_i) | (state_q == CALC));
   assign done_o      = (state_q == DONE);
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed scenarios plus randomized divisions vs. an arithmetic model.
// Latency: n/a (testbench).
// Backpressure: drives stall_i/flush_i directly.
module tb_alu_div;

   logic        clk;
   logic        resetn;
   logic        start_i;
   logic        signed_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        stall_i;
   logic        alu_stall_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;

   alu_div dut (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (start_i),
      .signed_i   (signed_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .flush_i    (flush_i),
      .stall_i    (stall_i),
      .alu_stall_o(alu_stall_o),
      .done_o     (done_o),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Architectural result of DIV/DIVU from plain arithmetic.
   task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] lo, output logic [31:0] hi);
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
      end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = 32'h8000_0000;
         hi = 32'd0;
      end else if (s) begin
         lo = 32'($signed(a) / $signed(b));
         hi = 32'($signed(a) % $signed(b));
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endtask

   function automatic int exp_stalls(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 1;
`endif
      return 33;
   endfunction

   // Call between a negedge and the following posedge. Returns in the first DONE cycle,
   // start_i still high.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input string tag);
      logic [31:0] elo, ehi;
      int stalls;
      bit got;
      ref_div(a, b, s, elo, ehi);
      start_i  = 1'b1;
      signed_i = s;
      a_i      = a;
      b_i      = b;
      stalls   = 0;
      got      = 1'b0;
      for (int cyc = 0; cyc < 100 && !got; cyc++) begin
         #1;
         if (done_o) begin
            got = 1'b1;
         end else begin
            if (alu_stall_o) stalls++;
            @(negedge clk);
         end
      end
      chk({tag, ".done"}, 32'(got), 32'd1);
      chk({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls(b)));
      chk({tag, ".stall_in_done"}, 32'(alu_stall_o), 32'd0);
      chk({tag, ".lo"}, lo_o, elo);
      chk({tag, ".hi"}, hi_o, ehi);
   endtask

   // Retire the instruction; the next cycle must be IDLE (no stall with start low, no done).
   task automatic finish_div(input string tag);
      start_i = 1'b0;
      stall_i = 1'b0;
      @(negedge clk);
      #1;
      chk({tag, ".idle_done"}, 32'(done_o), 32'd0);
      chk({tag, ".idle_stall"}, 32'(alu_stall_o), 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb, held_lo, held_hi;
      logic        rs;
      int          sel;

      resetn   = 1'b0;
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd1;
      b_i      = 32'd1;
      flush_i  = 1'b0;
      stall_i  = 1'b0;

      // Reset state, with start_i asserted to show it is ignored.
      repeat (2) @(negedge clk);
      #1;
      chk("reset.stall", 32'(alu_stall_o), 32'd0);
      chk("reset.done", 32'(done_o), 32'd0);
      chk("reset.hi", hi_o, 32'd0);
      chk("reset.lo", lo_o, 32'd0);
      start_i = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Basic unsigned and signed cases.
      run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
      finish_div("divu_100_7");
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      finish_div("div_m7_2");
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
      finish_div("div_ovf");
      run_div(32'd5, 32'd0, 1'b0, "divu_5_0");
      finish_div("divu_5_0");
      run_div(32'hFFFF_FFFB, 32'd0, 1'b1, "div_m5_0");
      finish_div("div_m5_0");

      // Flush at CALC cycle 10: abort, results held, no done.
      held_lo  = lo_o;
      held_hi  = hi_o;
      start_i  = 1'b1;
      signed_i = 1'b0;
      a_i      = 32'd1000;
      b_i      = 32'd3;
      repeat (10) @(negedge clk);
      #1;
      chk("flush.pre_stall", 32'(alu_stall_o), 32'd1);
      flush_i = 1'b1;
      #1;
      chk("flush.same_cycle_stall", 32'(alu_stall_o), 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("flush.idle_stall", 32'(alu_stall_o), 32'd0);
         chk("flush.no_done", 32'(done_o), 32'd0);
         @(negedge clk);
      end
      chk("flush.lo_held", lo_o, held_lo);
      chk("flush.hi_held", hi_o, held_hi);
      run_div(32'd9, 32'd3, 1'b0, "divu_9_3");
      finish_div("divu_9_3");

      // stall_i held for 5 cycles in DONE with start_i still high.
      run_div(32'd1234567, 32'd1000, 1'b0, "hold");
      held_lo = lo_o;
      held_hi = hi_o;
      stall_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         chk("hold.done", 32'(done_o), 32'd1);
         chk("hold.stall", 32'(alu_stall_o), 32'd0);
         chk("hold.lo", lo_o, held_lo);
         chk("hold.hi", hi_o, held_hi);
      end
      finish_div("hold");

      // Reset during CALC cycle 20, then an immediate new division.
      start_i  = 1'b1;
      signed_i = 1'b1;
      a_i      = 32'd77777;
      b_i      = 32'd13;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_calc.stall", 32'(alu_stall_o), 32'd0);
      chk("rst_calc.done", 32'(done_o), 32'd0);
      chk("rst_calc.hi", hi_o, 32'd0);
      chk("rst_calc.lo", lo_o, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      run_div(32'd6, 32'd3, 1'b0, "rst_then_6_3");
      finish_div("rst_then_6_3");

      // Randomized divisions with biased corner operands.
      for (int i = 0; i < 40; i++) begin
         ra  = $urandom;
         rb  = $urandom;
         rs  = 1'($urandom_range(0, 1));
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         if (sel == 1) rb = 32'hFFFF_FFFF;
         if (sel == 2) ra = 32'h8000_0000;
         if (sel == 3) rb = $urandom_range(1, 15);
         if (sel == 4) ra = $urandom_range(0, 1000);
         run_div(ra, rb, rs, "rand");
         finish_div("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
